// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES job scheduler and its FIFOs.
package aes_sched_pkg;

  typedef logic [127:0] block_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Widest requester ID the scheduler supports (up to 8 requesters).
  localparam int MAX_ID_W = 3;

  function automatic int id_width(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    block_t              data;
  } rsp_entry_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A pop on an empty FIFO is ignored, and a push to a full FIFO is accepted only with a same-cycle pop.
module aes_sched_fifo
  import aes_sched_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES core between NUM_REQ requesters.
// A credit counter bounds jobs in the core plus buffered results, so core output is never dropped.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  MAX_INFLIGHT = 16,
  parameter int  SERIAL       = 0,
  localparam int ID_W         = id_width(NUM_REQ),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ-1:0]     req_mode,
  output logic                   core_start,
  output logic                   core_valid_in,
  output logic                   core_mode,
  output logic [127:0]           core_data_in,
  output logic [127:0]           core_key_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_valid_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       credit_cnt,
  output logic                   err_orphan
);

  block_t             req_blk [NUM_REQ];
  block_t             key_blk [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               can_issue;
  logic               accept;
  logic               ret_ok;
  logic               rsp_pop;
  logic [ID_W-1:0]    tag_head;
  logic               tag_full, tag_empty, res_full, res_empty;
  logic [CNT_W-1:0]   tag_count, res_count;
  logic [ID_W+127:0]  res_dout;
  logic               unused_fifo_status;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_blk[g] = req_data[128*g +: 128];
    assign key_blk[g] = req_key[128*g +: 128];
  end

  // Cyclic search starting just after the last granted requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_issue = (credit_cnt < CNT_W'(MAX_INFLIGHT)) && (SERIAL == 0 || credit_cnt == '0);
  assign accept    = can_issue & found;
  assign req_ready = can_issue ? grant : '0;

  assign ret_ok  = core_valid_out & ~tag_empty;
  assign rsp_pop = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      core_start    <= 1'b0;
      core_valid_in <= 1'b0;
      core_mode     <= 1'b0;
      core_data_in  <= '0;
      core_key_in   <= '0;
      credit_cnt    <= '0;
      err_orphan    <= 1'b0;
    end else begin
      core_start    <= accept;
      core_valid_in <= accept;
      if (accept) begin
        rr_ptr       <= grant_idx;
        core_mode    <= req_mode[grant_idx];
        core_data_in <= req_blk[grant_idx];
        core_key_in  <= key_blk[grant_idx];
      end
      if (core_valid_out && tag_empty) err_orphan <= 1'b1;
      credit_cnt <= credit_cnt + CNT_W'(accept) - CNT_W'(rsp_pop);
    end
  end

  aes_sched_fifo #(.WIDTH(ID_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (grant_idx),
    .pop   (ret_ok),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  aes_sched_fifo #(.WIDTH(ID_W + 128), .DEPTH(MAX_INFLIGHT)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_ok),
    .din   ({tag_head, core_data_out}),
    .pop   (rsp_pop),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // Head is masked while empty so the response bus reads zero rather than stale storage.
  assign rsp_valid = ~res_empty;
  assign rsp_data  = rsp_valid ? res_dout[127:0] : '0;
  assign rsp_id    = rsp_valid ? res_dout[ID_W+127:128] : '0;

  // Credit alone prevents overflow; full flags and counts are not needed here.
  assign unused_fifo_status = ^{tag_full, res_full, tag_count, res_count};

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a fixed-latency stand-in for the AES core.
module tb_aes_job_scheduler;
  import aes_sched_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 5;
  localparam block_t KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]     req_valid, req_ready, req_mode;
  logic [NR*128-1:0] req_data, req_key;
  logic              core_start, core_valid_in, core_mode, core_valid_out;
  block_t            core_data_in, core_key_in, core_data_out, rsp_data;
  logic              rsp_valid, rsp_ready, err_orphan, inject;
  logic [1:0]        rsp_id;
  logic [4:0]        credit_cnt;

  logic [NR-1:0]     s_req_valid, s_req_ready, s_req_mode;
  logic [NR*128-1:0] s_req_data, s_req_key;
  logic              s_core_start, s_core_valid_in, s_core_mode, s_core_valid_out;
  block_t            s_core_data_in, s_core_key_in, s_core_data_out, s_rsp_data;
  logic              s_rsp_valid, s_rsp_ready, s_err_orphan;
  logic [1:0]        s_rsp_id;
  logic [4:0]        s_credit_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  rsp_entry_t exp_q[$];
  int ord_q[$];

  aes_job_scheduler #(.NUM_REQ(NR), .MAX_INFLIGHT(16), .SERIAL(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .req_mode(req_mode),
    .core_start(core_start), .core_valid_in(core_valid_in), .core_mode(core_mode),
    .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_valid_out(core_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .credit_cnt(credit_cnt), .err_orphan(err_orphan)
  );

  aes_job_scheduler #(.NUM_REQ(NR), .MAX_INFLIGHT(16), .SERIAL(1)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_data(s_req_data), .req_key(s_req_key), .req_mode(s_req_mode),
    .core_start(s_core_start), .core_valid_in(s_core_valid_in), .core_mode(s_core_mode),
    .core_data_in(s_core_data_in), .core_key_in(s_core_key_in),
    .core_data_out(s_core_data_out), .core_valid_out(s_core_valid_out),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
    .credit_cnt(s_credit_cnt), .err_orphan(s_err_orphan)
  );

  // Core stand-in: only the reference vector is real AES, anything else is a cheap reversible mix.
  function automatic block_t core_fn(input block_t d, input block_t k, input logic m);
    if (d == PT0 && k == KEY0 && m == MODE_ENC) return CT0;
    return {d[63:0], d[127:64]} ^ k ^ {128{m}};
  endfunction

  logic [LAT-1:0] pv, s_pv;
  block_t         pd [LAT];
  block_t         s_pd [LAT];

  always @(posedge clk) begin
    if (rst) begin
      pv   <= '0;
      s_pv <= '0;
    end else begin
      pv      <= {pv[LAT-2:0], core_valid_in & core_start};
      s_pv    <= {s_pv[LAT-2:0], s_core_valid_in & s_core_start};
      pd[0]   <= core_fn(core_data_in, core_key_in, core_mode);
      s_pd[0] <= core_fn(s_core_data_in, s_core_key_in, s_core_mode);
      for (int i = 1; i < LAT; i++) begin
        pd[i]   <= pd[i-1];
        s_pd[i] <= s_pd[i-1];
      end
    end
  end

  assign core_valid_out   = pv[LAT-1] | inject;
  assign core_data_out    = pd[LAT-1];
  assign s_core_valid_out = s_pv[LAT-1];
  assign s_core_data_out  = s_pd[LAT-1];

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    s_req_valid = '0;
    inject = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    ord_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 132'(exp_q.size()), 132'(0));
  endtask

  // Scoreboard for the pipelined DUT: record accepts, check every response pop in order.
  always @(negedge clk) begin
    if (!rst) begin
      rsp_entry_t e;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = MAX_ID_W'(i);
          e.data = core_fn(req_data[128*i +: 128], req_key[128*i +: 128], req_mode[i]);
          exp_q.push_back(e);
          ord_q.push_back(i);
        end
      end
      chk("ready_onehot", 132'($countones(req_ready) <= 1), 132'(1));
      chk("credit_bound", 132'(credit_cnt <= 5'd16), 132'(1));
      chk("s_credit_bound", 132'(s_credit_cnt <= 5'd1), 132'(1));
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 132'(exp_q.size() > 0), 132'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_id", 132'(rsp_id), 132'(e.id));
          chk("rsp_data", 132'(rsp_data), 132'(e.data));
          n_rsp++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   base;
    logic prev_cvo;
    block_t s_exp0, s_exp1;

    req_valid = '0; req_mode = '0; req_data = '0; req_key = '0;
    s_req_valid = '0; s_req_mode = '0; s_req_data = '0; s_req_key = '0;
    rsp_ready = 1'b1; s_rsp_ready = 1'b1; inject = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_credit", 132'(credit_cnt), 132'(0));
    chk("rst_rsp_valid", 132'(rsp_valid), 132'(0));
    chk("rst_core_valid", 132'(core_valid_in), 132'(0));
    chk("rst_core_start", 132'(core_start), 132'(0));
    chk("rst_orphan", 132'(err_orphan), 132'(0));
    chk("rst_rsp_data", 132'(rsp_data), 132'(0));
    chk("rst_core_data", 132'(core_data_in), 132'(0));

    // Single job from requester 2 with the reference AES vector.
    req_data[2*128 +: 128] = PT0;
    req_key[2*128 +: 128]  = KEY0;
    req_mode[2] = MODE_ENC;
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", 132'(req_ready), 132'(4'b0100));
    step();
    req_valid = '0;
    chk("t1_core_valid", 132'(core_valid_in), 132'(1));
    chk("t1_core_start", 132'(core_start), 132'(1));
    chk("t1_core_data", 132'(core_data_in), 132'(PT0));
    chk("t1_core_key", 132'(core_key_in), 132'(KEY0));
    chk("t1_credit1", 132'(credit_cnt), 132'(1));
    step();
    chk("t1_core_pulse", 132'(core_valid_in), 132'(0));
    n = 0;
    prev_cvo = 1'b0;
    while (!rsp_valid && n < 20) begin
      prev_cvo = core_valid_out;
      step();
      n++;
    end
    chk("t1_rsp_valid", 132'(rsp_valid), 132'(1));
    chk("t1_rsp_latency", 132'(prev_cvo), 132'(1));
    chk("t1_rsp_data", 132'(rsp_data), 132'(CT0));
    chk("t1_rsp_id", 132'(rsp_id), 132'(2));
    step();
    chk("t1_credit0", 132'(credit_cnt), 132'(0));

    // All requesters valid: grants rotate 0,1,2,3 one per cycle.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_data[128*i +: 128] = PT0 ^ {16{8'(i + 1)}};
      req_key[128*i +: 128]  = KEY0 ^ 128'(i);
      req_mode[i] = i[0];
    end
    req_valid = 4'hF;
    repeat (8) step();
    req_valid = '0;
    wait_drain("t2_drain", 40);
    chk("t2_accepts", 132'(ord_q.size()), 132'(8));
    for (int k = 0; k < 8 && k < ord_q.size(); k++) chk("t2_order", 132'(ord_q[k]), 132'(k % NR));
    step();
    chk("t2_credit0", 132'(credit_cnt), 132'(0));

    // Backpressure: credit stops issue at 16, then resumes as responses drain.
    do_reset();
    base = n_rsp;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (24) step();
    chk("t3_accepts", 132'(ord_q.size()), 132'(16));
    chk("t3_ready_zero", 132'(req_ready), 132'(0));
    chk("t3_credit16", 132'(credit_cnt), 132'(16));
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("t3_resume", 132'(ord_q.size() > 16), 132'(1));
    req_valid = '0;
    wait_drain("t3_drain", 120);
    chk("t3_rsp_count", 132'(n_rsp - base), 132'(ord_q.size()));

    // Reset with five jobs outstanding discards everything.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (5) step();
    req_valid = '0;
    repeat (3) step();
    chk("t4_credit5", 132'(credit_cnt), 132'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_credit0", 132'(credit_cnt), 132'(0));
    chk("t4_rsp_valid", 132'(rsp_valid), 132'(0));
    chk("t4_core_valid", 132'(core_valid_in), 132'(0));
    chk("t4_core_data", 132'(core_data_in), 132'(0));
    chk("t4_rsp_id", 132'(rsp_id), 132'(0));
    exp_q.delete();
    rsp_ready = 1'b1;
    repeat (12) begin
      step();
      chk("t4_no_rsp", 132'(rsp_valid), 132'(0));
      chk("t4_no_orphan", 132'(err_orphan), 132'(0));
    end

    // Serial core: requester 1 waits for requester 0's response to pop.
    do_reset();
    s_req_data[0 +: 128]   = PT0 ^ {16{8'h55}};
    s_req_key[0 +: 128]    = KEY0;
    s_req_data[128 +: 128] = PT0 ^ {16{8'haa}};
    s_req_key[128 +: 128]  = KEY0 ^ 128'h1;
    s_req_mode = 4'b0010;
    s_exp0 = core_fn(PT0 ^ {16{8'h55}}, KEY0, 1'b0);
    s_exp1 = core_fn(PT0 ^ {16{8'haa}}, KEY0 ^ 128'h1, 1'b1);
    s_req_valid = 4'b0011;
    #1;
    chk("t5_grant0", 132'(s_req_ready), 132'(4'b0001));
    step();
    s_req_valid = 4'b0010;
    #1;
    chk("t5_block", 132'(s_req_ready), 132'(0));
    chk("t5_credit1", 132'(s_credit_cnt), 132'(1));
    n = 0;
    while (!s_rsp_valid && n < 20) begin
      step();
      chk("t5_hold", 132'(s_req_ready), 132'(0));
      n++;
    end
    chk("t5_rsp0_valid", 132'(s_rsp_valid), 132'(1));
    chk("t5_rsp0_id", 132'(s_rsp_id), 132'(0));
    chk("t5_rsp0_data", 132'(s_rsp_data), 132'(s_exp0));
    step();
    chk("t5_grant1", 132'(s_req_ready), 132'(4'b0010));
    chk("t5_credit0", 132'(s_credit_cnt), 132'(0));
    step();
    s_req_valid = '0;
    n = 0;
    while (!s_rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("t5_rsp1_valid", 132'(s_rsp_valid), 132'(1));
    chk("t5_rsp1_id", 132'(s_rsp_id), 132'(1));
    chk("t5_rsp1_data", 132'(s_rsp_data), 132'(s_exp1));
    step();

    // Orphan core result: sticky flag, nothing buffered, no credit change.
    do_reset();
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("t6_orphan", 132'(err_orphan), 132'(1));
    chk("t6_rsp_valid", 132'(rsp_valid), 132'(0));
    chk("t6_credit", 132'(credit_cnt), 132'(0));
    repeat (3) step();
    chk("t6_orphan_sticky", 132'(err_orphan), 132'(1));
    chk("t6_rsp_valid_late", 132'(rsp_valid), 132'(0));
    chk("t6_credit_late", 132'(credit_cnt), 132'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
